// File: rtl/lisp_pkg.sv
// rtl/lisp_pkg.sv - shared heap word, address and pointer-tag definitions
//
// Purpose: common types for the lisp core and its heap memory. A tagged
// pointer word is laid out as {flag, tag[2:0], address[11:0]}. The flag bit
// is always zero for heap pointers.
// Ports: none (package).
package lisp_pkg;

  typedef logic [11:0] address_t;
  typedef logic [15:0] word_t;

  typedef enum logic [2:0] {
    TYPE_NUMBER = 3'd0,
    TYPE_CONS   = 3'd1
  } tag_t;

  localparam int PTR_FLAG_BIT = 15;
  localparam int PTR_TAG_MSB  = 14;
  localparam int PTR_TAG_LSB  = 12;
  localparam int PTR_ADDR_MSB = 11;
  localparam int PTR_ADDR_LSB = 0;

  // Build a tagged heap pointer word from a tag and a cell base address.
  function automatic word_t make_ptr(input tag_t tag, input address_t addr);
    word_t p;
    p = '0;
    p[PTR_FLAG_BIT]                = 1'b0;
    p[PTR_TAG_MSB:PTR_TAG_LSB]     = tag;
    p[PTR_ADDR_MSB:PTR_ADDR_LSB]   = addr;
    return p;
  endfunction

endpackage

// File: rtl/cons_allocator.sv
// rtl/cons_allocator.sv - bump allocator for two-word cons cells
//
// Purpose: accepts one allocation request at a time, writes the car and cdr
// words into consecutive heap addresses and returns a tagged cons pointer.
// The heap only grows; heap_clear discards every cell at once.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   alloc_req/car/cdr      allocation request and the two cell words
//   alloc_ready            request accepted this cycle if alloc_req is high
//   alloc_done/alloc_ptr   one-cycle completion pulse and tagged pointer
//   alloc_error            heap exhausted, held until heap_clear or rst
//   heap_clear             pulse that resets the heap to empty
//   mem_we/addr/wdata      write-only port into the heap memory
//   free_ptr               next free cell address (debug)
module cons_allocator
  import lisp_pkg::*;
#(
  parameter address_t HEAP_BASE  = 12'h100,
  parameter address_t HEAP_LIMIT = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alloc_req,
  input  logic [15:0] alloc_car,
  input  logic [15:0] alloc_cdr,
  output logic        alloc_ready,
  output logic        alloc_done,
  output logic [15:0] alloc_ptr,
  output logic        alloc_error,
  input  logic        heap_clear,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [11:0] free_ptr
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITE_CAR = 3'd1,
    S_WRITE_CDR = 3'd2,
    S_DONE      = 3'd3,
    S_FULL      = 3'd4
  } state_t;

  state_t      state_q;
  state_t      state_d;

  // One bit wider than an address: after the last cell ends at 0xFFF the
  // pointer reaches 0x1000 and must not wrap back into the heap.
  logic [12:0] free_q;
  word_t       car_q;
  word_t       cdr_q;
  word_t       ptr_q;
  logic        error_q;
  logic        room;

  assign room = (free_q + 13'd1) <= {1'b0, HEAP_LIMIT};

  assign free_ptr    = free_q[11:0];
  assign alloc_ptr   = ptr_q;
  assign alloc_error = error_q;

  // Next state and Moore outputs; every output depends on state only.
  always_comb begin
    state_d     = state_q;
    alloc_ready = 1'b0;
    alloc_done  = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state_q)
      S_IDLE: begin
        alloc_ready = 1'b1;
        if (heap_clear) begin
          state_d = S_IDLE;
        end else if (alloc_req) begin
          state_d = room ? S_WRITE_CAR : S_FULL;
        end
      end
      S_WRITE_CAR: begin
        mem_we    = 1'b1;
        mem_addr  = free_q[11:0];
        mem_wdata = car_q;
        state_d   = S_WRITE_CDR;
      end
      S_WRITE_CDR: begin
        mem_we    = 1'b1;
        mem_addr  = free_q[11:0] + 12'd1;
        mem_wdata = cdr_q;
        state_d   = S_DONE;
      end
      S_DONE: begin
        alloc_done = 1'b1;
        state_d    = S_IDLE;
      end
      S_FULL: begin
        if (heap_clear) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      free_q  <= {1'b0, HEAP_BASE};
      car_q   <= '0;
      cdr_q   <= '0;
      ptr_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (heap_clear) begin
            free_q  <= {1'b0, HEAP_BASE};
            error_q <= 1'b0;
          end else if (alloc_req) begin
            if (room) begin
              car_q <= alloc_car;
              cdr_q <= alloc_cdr;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        // Pointer is loaded on entry to Done so it is valid with the pulse,
        // then held until the next completed cell.
        S_WRITE_CDR: begin
          ptr_q <= make_ptr(TYPE_CONS, free_q[11:0]);
        end
        S_DONE: begin
          free_q <= free_q + 13'd2;
        end
        S_FULL: begin
          if (heap_clear) begin
            free_q  <= {1'b0, HEAP_BASE};
            error_q <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cons_allocator.sv
// tb/tb_cons_allocator.sv - randomized and directed bench for cons_allocator
module tb_cons_allocator;
  import lisp_pkg::*;

  localparam logic [11:0] A_BASE  = 12'h100;
  localparam logic [11:0] A_LIMIT = 12'hFFF;
  localparam logic [11:0] B_BASE  = 12'hFFC;
  localparam logic [11:0] B_LIMIT = 12'hFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, alloc_req, heap_clear;
  logic [15:0] alloc_car, alloc_cdr;
  logic        alloc_ready, alloc_done, alloc_error, mem_we;
  logic [15:0] alloc_ptr, mem_wdata;
  logic [11:0] mem_addr, free_ptr;

  logic        b_rst, b_req, b_clear;
  logic [15:0] b_car, b_cdr;
  logic        b_ready, b_done, b_error, b_we;
  logic [15:0] b_ptr, b_wdata;
  logic [11:0] b_addr, b_free;

  cons_allocator #(.HEAP_BASE(A_BASE), .HEAP_LIMIT(A_LIMIT)) dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_car(alloc_car),
    .alloc_cdr(alloc_cdr), .alloc_ready(alloc_ready), .alloc_done(alloc_done),
    .alloc_ptr(alloc_ptr), .alloc_error(alloc_error), .heap_clear(heap_clear),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .free_ptr(free_ptr)
  );

  cons_allocator #(.HEAP_BASE(B_BASE), .HEAP_LIMIT(B_LIMIT)) dut_b (
    .clk(clk), .rst(b_rst), .alloc_req(b_req), .alloc_car(b_car),
    .alloc_cdr(b_cdr), .alloc_ready(b_ready), .alloc_done(b_done),
    .alloc_ptr(b_ptr), .alloc_error(b_error), .heap_clear(b_clear),
    .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .free_ptr(b_free)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for instance A: a cell is a 3-cycle transaction counted
  // from the accepting edge; the heap is a bump pointer.
  int          m_phase = 0;
  bit          m_full  = 1'b0;
  bit          m_err   = 1'b0;
  int          m_free  = int'(A_BASE);
  logic [15:0] m_car   = '0;
  logic [15:0] m_cdr   = '0;
  logic [15:0] m_ptr   = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_full  <= 1'b0;
      m_err   <= 1'b0;
      m_free  <= int'(A_BASE);
      m_car   <= '0;
      m_cdr   <= '0;
      m_ptr   <= '0;
    end else if (m_full) begin
      if (heap_clear) begin
        m_full <= 1'b0;
        m_err  <= 1'b0;
        m_free <= int'(A_BASE);
      end
    end else if (m_phase == 0) begin
      if (heap_clear) begin
        m_free <= int'(A_BASE);
        m_err  <= 1'b0;
      end else if (alloc_req) begin
        if (m_free + 1 <= int'(A_LIMIT)) begin
          m_phase <= 1;
          m_car   <= alloc_car;
          m_cdr   <= alloc_cdr;
        end else begin
          m_full <= 1'b1;
          m_err  <= 1'b1;
        end
      end
    end else if (m_phase == 3) begin
      m_phase <= 0;
      m_ptr   <= 16'h1000 | {4'h0, m_free[11:0]};
      m_free  <= m_free + 2;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  bit cmp_en = 1'b0;

  logic [27:0] wlog[$];
  logic [15:0] dlog[$];
  logic [27:0] b_wlog[$];
  logic [15:0] b_dlog[$];

  always @(negedge clk) begin
    logic [11:0] e_addr;
    logic [15:0] e_wdata;
    logic [15:0] e_ptr;
    if (mem_we)   wlog.push_back({mem_addr, mem_wdata});
    if (alloc_done) dlog.push_back(alloc_ptr);
    if (b_we)     b_wlog.push_back({b_addr, b_wdata});
    if (b_done)   b_dlog.push_back(b_ptr);
    if (cmp_en) begin
      e_addr  = (m_phase == 1) ? m_free[11:0] : (m_phase == 2) ? 12'(m_free + 1) : 12'h000;
      e_wdata = (m_phase == 1) ? m_car : (m_phase == 2) ? m_cdr : 16'h0000;
      e_ptr   = (m_phase == 3) ? (16'h1000 | {4'h0, m_free[11:0]}) : m_ptr;
      check("ready", alloc_ready, (m_phase == 0) && !m_full);
      check("mem_we", mem_we, (m_phase == 1) || (m_phase == 2));
      check("mem_addr", mem_addr, e_addr);
      check("mem_wdata", mem_wdata, e_wdata);
      check("done", alloc_done, m_phase == 3);
      check("ptr", alloc_ptr, e_ptr);
      check("error", alloc_error, m_err);
      check("free_ptr", free_ptr, m_free[11:0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_rst();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int dcount;
    int wcount;
    rst = 1'b1; alloc_req = 1'b0; heap_clear = 1'b0; alloc_car = '0; alloc_cdr = '0;
    b_rst = 1'b1; b_req = 1'b0; b_clear = 1'b0; b_car = '0; b_cdr = '0;
    repeat (2) tick();
    cmp_en = 1'b1;
    check("rst_ptr_lit", alloc_ptr, 16'h0000);
    check("rst_free_lit", free_ptr, 12'h100);
    check("rst_we_lit", mem_we, 1'b0);
    check("rst_err_lit", alloc_error, 1'b0);
    rst = 1'b0; b_rst = 1'b0;
    #1 check("ready_after_rst_lit", alloc_ready, 1'b1);
    tick();

    // first cell after reset: car=5, cdr=7
    wlog.delete(); dlog.delete();
    alloc_car = 16'h0005; alloc_cdr = 16'h0007; alloc_req = 1'b1;
    tick(); alloc_req = 1'b0;
    check("c1_car_we", mem_we, 1'b1);
    check("c1_car_addr", mem_addr, 12'h100);
    check("c1_car_data", mem_wdata, 16'h0005);
    tick();
    check("c1_cdr_addr", mem_addr, 12'h101);
    check("c1_cdr_data", mem_wdata, 16'h0007);
    tick();
    check("c1_done", alloc_done, 1'b1);
    check("c1_ptr", alloc_ptr, 16'h1100);
    tick();
    check("c1_ready_again", alloc_ready, 1'b1);
    check("c1_free", free_ptr, 12'h102);
    check("c1_nwrites", wlog.size(), 2);

    // three back-to-back cells with alloc_req held high
    do_rst();
    wlog.delete(); dlog.delete();
    alloc_req = 1'b1; alloc_car = 16'($urandom); alloc_cdr = 16'($urandom);
    repeat (12) begin
      tick();
      alloc_car = 16'($urandom); alloc_cdr = 16'($urandom);
    end
    alloc_req = 1'b0;
    repeat (3) tick();
    check("b2b_ndone", dlog.size(), 3);
    check("b2b_nwrites", wlog.size(), 6);
    if (dlog.size() == 3) begin
      check("b2b_ptr0", dlog[0], 16'h1100);
      check("b2b_ptr1", dlog[1], 16'h1102);
      check("b2b_ptr2", dlog[2], 16'h1104);
    end

    // heap_clear during WriteCar is ignored
    alloc_req = 1'b1; alloc_car = 16'hBEEF; alloc_cdr = 16'h0F00;
    tick(); alloc_req = 1'b0; heap_clear = 1'b1;
    tick(); heap_clear = 1'b0;
    repeat (3) tick();
    check("clr_in_car_free", free_ptr, 12'h108);

    // reset during WriteCdr abandons the cell
    dcount = dlog.size();
    alloc_req = 1'b1;
    tick(); alloc_req = 1'b0;
    tick();
    check("mid_rst_in_cdr", mem_we, 1'b1);
    rst = 1'b1;
    #1 check("mid_rst_we_drop", mem_we, 1'b0);
    check("mid_rst_free", free_ptr, 12'h100);
    tick(); rst = 1'b0;
    #1 check("mid_rst_ready", alloc_ready, 1'b1);
    repeat (4) tick();
    check("mid_rst_no_done", dlog.size(), dcount);
    check("mid_rst_free_after", free_ptr, 12'h100);

    // randomized traffic against the model
    repeat (600) begin
      tick();
      alloc_req  = ($urandom_range(0, 9) < 6);
      heap_clear = ($urandom_range(0, 19) == 0);
      alloc_car  = 16'($urandom);
      alloc_cdr  = 16'($urandom);
      rst        = ($urandom_range(0, 149) == 0);
    end
    alloc_req = 1'b0; heap_clear = 1'b0; rst = 1'b0;

    // fill the whole heap until it reports exhaustion
    do_rst();
    wlog.delete(); dlog.delete();
    alloc_req = 1'b1;
    n = 0;
    while (!alloc_error && n < 9000) begin
      alloc_car = 16'($urandom); alloc_cdr = 16'($urandom);
      tick();
      n++;
    end
    check("fill_reached_full", alloc_error, 1'b1);
    repeat (3) tick();
    alloc_req = 1'b0;
    tick();
    check("fill_ndone", dlog.size(), 1920);
    if (dlog.size() > 0) check("fill_last_ptr", dlog[dlog.size() - 1], 16'h1FFE);
    check("fill_ready", alloc_ready, 1'b0);
    check("fill_err_held", alloc_error, 1'b1);

    // clear together with a request from Full
    wcount = wlog.size();
    heap_clear = 1'b1; alloc_req = 1'b1;
    tick(); heap_clear = 1'b0; alloc_req = 1'b0;
    check("full_clr_err", alloc_error, 1'b0);
    check("full_clr_free", free_ptr, 12'h100);
    check("full_clr_ready", alloc_ready, 1'b1);
    check("full_clr_nowrite", wlog.size(), wcount);
    alloc_req = 1'b1; alloc_car = 16'hABCD; alloc_cdr = 16'h1234;
    tick(); alloc_req = 1'b0;
    tick(); tick();
    check("post_clr_done", alloc_done, 1'b1);
    check("post_clr_ptr", alloc_ptr, 16'h1100);
    if (wlog.size() == wcount + 2) begin
      check("post_clr_w0", wlog[wcount], {12'h100, 16'hABCD});
      check("post_clr_w1", wlog[wcount + 1], {12'h101, 16'h1234});
    end else begin
      check("post_clr_nwrites", wlog.size(), wcount + 2);
    end
    tick();

    // small heap: two cells fit, the third exhausts it
    b_req = 1'b1;
    n = 0;
    while (!b_error && n < 20) begin
      b_car = 16'($urandom); b_cdr = 16'($urandom);
      tick();
      n++;
    end
    b_req = 1'b0;
    check("small_err", b_error, 1'b1);
    tick();
    check("small_ready", b_ready, 1'b0);
    check("small_we", b_we, 1'b0);
    check("small_ndone", b_dlog.size(), 2);
    check("small_nwrites", b_wlog.size(), 4);
    if (b_dlog.size() == 2) begin
      check("small_ptr0", b_dlog[0], 16'h1FFC);
      check("small_ptr1", b_dlog[1], 16'h1FFE);
    end
    if (b_wlog.size() == 4) begin
      check("small_a3", b_wlog[3][27:16], 12'hFFF);
    end
    b_clear = 1'b1;
    tick(); b_clear = 1'b0;
    check("small_clr_free", b_free, 12'hFFC);
    check("small_clr_err", b_error, 1'b0);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cons_allocator.md
CONS_ALLOCATOR -- requirements
Module: cons_allocator

Interface
REQ-001 Parameter HEAP_BASE, default 12'h100: first heap word address; SHALL be even.
REQ-002 Parameter HEAP_LIMIT, default 12'hFFF: last heap word address usable by a cell.
REQ-003 clk  in  1  sole clock; all state SHALL update on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 alloc_req  in  1  request a new cons cell; sampled only while alloc_ready is high.
REQ-006 alloc_car  in  16  car word for the cell.
REQ-007 alloc_cdr  in  16  cdr word for the cell.
REQ-008 alloc_ready  out  1  high when a request can be accepted.
REQ-009 alloc_done  out  1  one-cycle pulse when alloc_ptr is valid.
REQ-010 alloc_ptr  out  16  tagged cons pointer: bit15=0, bits[14:12]=TYPE_CONS, bits[11:0]=cell base address.
REQ-011 alloc_error  out  1  heap exhausted; held until rst or heap_clear.
REQ-012 heap_clear  in  1  single-cycle pulse; discards all cells.
REQ-013 mem_we  out  1  heap write strobe; write-only port into the memory block.
REQ-014 mem_addr  out  12  heap write address.
REQ-015 mem_wdata  out  16  heap write data.
REQ-016 free_ptr  out  12  next free cell address, for debug/LEDs.

Function
REQ-017 States SHALL be Idle, WriteCar, WriteCdr, Done, Full.
REQ-018 alloc_ready SHALL be high exactly in Idle.
REQ-019 Idle + alloc_req + no heap_clear + room available: latch car/cdr, go to WriteCar.
REQ-020 Room available means free_ptr+1 <= HEAP_LIMIT, computed in 13 bits with no wrap.
REQ-021 Idle + alloc_req + no room: go to Full with no memory write; alloc_error rises next cycle.
REQ-022 WriteCar: mem_we=1, mem_addr=free_ptr, mem_wdata=latched car; go to WriteCdr.
REQ-023 WriteCdr: mem_we=1, mem_addr=free_ptr+1, mem_wdata=latched cdr; go to Done.
REQ-024 Done: alloc_done=1, alloc_ptr={1'b0,TYPE_CONS,free_ptr}; free_ptr += 2 at the clock edge; go to Idle.
REQ-025 Latency: request accepted at edge N, car written cycle N+1, cdr N+2, alloc_done high cycle N+3, alloc_ready high again cycle N+4.
REQ-026 alloc_ptr SHALL hold its last value until the next Done.
REQ-027 mem_we SHALL be 0 in every state except WriteCar and WriteCdr; mem_addr and mem_wdata SHALL be 0 when mem_we=0.
REQ-028 alloc_req outside Idle SHALL be ignored and not queued.
REQ-029 heap_clear in Idle or Full: free_ptr <= HEAP_BASE, alloc_error <= 0, state <= Idle.
REQ-030 heap_clear and alloc_req in the same Idle cycle: clear wins, request not accepted.
REQ-031 heap_clear in WriteCar, WriteCdr or Done SHALL be ignored.
REQ-032 Full SHALL be left only by heap_clear or rst.
REQ-033 Car and cdr SHALL be written verbatim; no tag checking of their contents.

Reset
REQ-034 rst asserted: state=Idle, free_ptr=HEAP_BASE, alloc_ptr=0, alloc_done=0, alloc_error=0, mem_we=0, mem_addr=0, mem_wdata=0, latched car/cdr=0.
REQ-035 rst mid-allocation SHALL abandon the cell: no further writes, no alloc_done, free_ptr not advanced.
REQ-036 alloc_ready SHALL be high in the first cycle after rst deasserts.

Structure
REQ-037 Shared package lisp_pkg SHALL hold address_t (12b), word_t (16b), tag_t with TYPE_NUMBER=0 and TYPE_CONS=1, and the pointer-tag field positions; core and memory SHALL import the same package.
REQ-038 The state enum SHALL be local to cons_allocator.
REQ-039 No sub-module is required; the allocator is a single FSM plus one pointer register.

Verification
REQ-040 Reset, then car=16'h0005, cdr=16'h0007 -> writes (0x100,0x0005) and (0x101,0x0007); alloc_ptr=16'h1100 on cycle N+3; free_ptr=0x102.
REQ-041 Three back-to-back requests with alloc_req held high -> alloc_ptr 16'h1100, 16'h1102, 16'h1104; exactly one alloc_done per cell; no extra writes.
REQ-042 HEAP_BASE=12'hFFC, HEAP_LIMIT=12'hFFF -> two cells succeed (0xFFC, 0xFFE); third request writes nothing, alloc_error=1, alloc_ready=0.
REQ-043 From Full, pulse heap_clear together with alloc_req -> alloc_error=0, free_ptr=HEAP_BASE, no write; the next alloc_req succeeds at HEAP_BASE.
REQ-044 Assert rst during WriteCdr -> mem_we drops immediately, no alloc_done, free_ptr=HEAP_BASE, alloc_ready=1 after release.
REQ-045 heap_clear pulsed during WriteCar -> allocation completes normally and free_ptr advances by 2.
